// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control/status bundle between the sequencer and the datapath/memory side.
interface cpu_sequencer_if #(parameter int INSTR_W = 8);
    logic               run;
    logic [INSTR_W-1:0] instruction;
    logic               acc_zero;
    logic               mem_ready;
    logic               instr_en;
    logic               pc_inc;
    logic               pc_load;
    logic               acc_en;
    logic               mem_rd;
    logic               mem_wr;
    logic [3:0]         alu_op;
    logic               halt;
    logic               fault;
    logic [2:0]         state;
    modport master (
        input  run, instruction, acc_zero, mem_ready,
        output instr_en, pc_inc, pc_load, acc_en, mem_rd, mem_wr, alu_op, halt, fault, state
    );
    modport slave (
        output run, instruction, acc_zero, mem_ready,
        input  instr_en, pc_inc, pc_load, acc_en, mem_rd, mem_wr, alu_op, halt, fault, state
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/memory sequencer for the 8-bit accumulator CPU.
// Outputs decode from the registered state and latched opcode; only LOAD's acc_en follows mem_ready.
module cpu_sequencer #(
    parameter int INSTR_W  = 8,
    parameter int OPC_W    = 4,
    parameter int WAIT_MAX = 15
) (
    input logic             clk,
    input logic             reset,
    cpu_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOADIR, DECODE, EXEC, MEMACC, HALTED, FAULT} state_t;
    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]    W_LAST   = CW'(WAIT_MAX - 1);
    localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(4'h0);
    localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(4'h1);
    localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(4'h2);
    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(4'h3);
    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(4'h4);
    localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(4'h5);
    localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(4'h6);
    localparam logic [OPC_W-1:0] OP_SKZ   = OPC_W'(4'h7);
    localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(4'h8);
    localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(4'hF);

    state_t           r_state;
    logic [OPC_W-1:0] r_opc;
    logic             r_zero;
    logic [CW-1:0]    r_cnt;
    logic [OPC_W-1:0] w_opc;
    state_t           w_dec;
    logic             w_alu;
    logic             w_unused;

    assign w_opc    = bus.instruction[INSTR_W-1 -: OPC_W];
    assign w_unused = ^bus.instruction;
    assign w_alu    = r_opc == OP_ADD || r_opc == OP_SUB || r_opc == OP_AND || r_opc == OP_XOR;

    always_comb
        w_dec = w_opc == OP_NOP ? FETCH :
                (w_opc == OP_ADD || w_opc == OP_SUB || w_opc == OP_AND || w_opc == OP_XOR ||
                 w_opc == OP_SKZ || w_opc == OP_JMP) ? EXEC :
                (w_opc == OP_LOAD || w_opc == OP_STORE) ? MEMACC :
                w_opc == OP_HALT ? HALTED : FAULT;

    // The wait counter is cleared by default, so it only survives while a bus wait continues.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state <= IDLE;
            r_opc   <= '0;
            r_zero  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_cnt <= '0;
            case (r_state)
                IDLE:          if (bus.run) r_state <= FETCH;
                FETCH, MEMACC: if (bus.mem_ready) r_state <= (r_state == FETCH) ? LOADIR : FETCH;
                               else if (r_cnt == W_LAST) r_state <= FAULT;
                               else r_cnt <= r_cnt + 1'b1;
                LOADIR:        r_state <= DECODE;
                DECODE: begin
                    r_opc   <= w_opc;
                    r_zero  <= bus.acc_zero;
                    r_state <= w_dec;
                end
                EXEC:          r_state <= FETCH;
                HALTED:        if (bus.run) r_state <= FETCH;
                default:       ;
            endcase
        end

    assign bus.state    = r_state;
    assign bus.instr_en = r_state == LOADIR;
    assign bus.pc_inc   = r_state == LOADIR || (r_state == EXEC && r_opc == OP_SKZ && r_zero);
    assign bus.pc_load  = r_state == EXEC && r_opc == OP_JMP;
    assign bus.acc_en   = (r_state == EXEC && w_alu) ||
                          (r_state == MEMACC && r_opc == OP_LOAD && bus.mem_ready);
    assign bus.mem_rd   = r_state == FETCH || (r_state == MEMACC && r_opc == OP_LOAD);
    assign bus.mem_wr   = r_state == MEMACC && r_opc == OP_STORE;
    assign bus.alu_op   = (r_state == EXEC && w_alu) ? r_opc[3:0] :
                          (r_state == MEMACC && r_opc == OP_LOAD) ? 4'b0011 : 4'b0000;
    assign bus.halt     = r_state == HALTED;
    assign bus.fault    = r_state == FAULT;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scenario tasks drive per-cycle stimulus and score DUT outputs against queued expectations.
module tb_cpu_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    cpu_sequencer_if #(.INSTR_W(8)) bus ();
    cpu_sequencer #(.INSTR_W(8), .OPC_W(4), .WAIT_MAX(15)) dut (.clk(clk), .reset(reset), .bus(bus.master));

    always #5 clk = ~clk;

    // expected word: {state, instr_en, pc_inc, pc_load, acc_en, mem_rd, mem_wr, alu_op, halt, fault}
    localparam logic [5:0] C0 = 6'b000000, C_RD = 6'b000010, C_IR = 6'b110000, C_AE = 6'b000100;
    localparam logic [5:0] C_LDA = 6'b000110, C_WR = 6'b000001, C_PI = 6'b010000, C_PL = 6'b001000;

    typedef struct packed {logic run; logic az; logic mr; logic [7:0] ins; logic [14:0] exp;} vec_t;

    logic [14:0] sb[$];
    vec_t        v[$];

    function automatic logic [14:0] ex(input logic [2:0] st, input logic [5:0] c, input logic [3:0] op, input logic [1:0] hf);
        return {st, c, op, hf};
    endfunction

    function automatic vec_t mk(input logic run, input logic az, input logic mr, input logic [7:0] ins, input logic [14:0] e);
        return '{run: run, az: az, mr: mr, ins: ins, exp: e};
    endfunction

    function automatic logic [14:0] obs();
        return {bus.state, bus.instr_en, bus.pc_inc, bus.pc_load, bus.acc_en, bus.mem_rd, bus.mem_wr,
                bus.alu_op, bus.halt, bus.fault};
    endfunction

    task automatic drive(input vec_t x);
        bus.run = x.run;
        bus.acc_zero = x.az;
        bus.mem_ready = x.mr;
        bus.instruction = x.ins;
        sb.push_back(x.exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        v.delete();
    endtask

    // Fetch prologue common to every program: IDLE, FETCH with immediate ready, LOADIR.
    task automatic prologue(input logic [7:0] ins);
        v.push_back(mk(1, 0, 1, ins, ex(0, C0, 0, 0)));
        v.push_back(mk(1, 0, 1, ins, ex(1, C_RD, 0, 0)));
        v.push_back(mk(1, 0, 1, ins, ex(2, C_IR, 0, 0)));
    endtask

    task automatic test_reset();
        logic [14:0] got, want;
        reset = 1'b1;
        bus.run = 1'b1;
        bus.acc_zero = 1'b1;
        bus.mem_ready = 1'b1;
        bus.instruction = 8'h15;
        repeat (2) begin
            @(negedge clk);
            sb.push_back(ex(0, C0, 0, 0));
            got = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("FAIL reset got=%h want=%h", got, want); end
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        logic [14:0] got, want;
        do_reset();
        prologue(8'h15);
        v.push_back(mk(1, 0, 1, 8'h15, ex(3, C0, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h15, ex(4, C_AE, 4'h1, 0)));
        v.push_back(mk(1, 0, 1, 8'h15, ex(1, C_RD, 0, 0)));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            got = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("FAIL add[%0d] got=%h want=%h", i, got, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] got, want;
        do_reset();
        prologue(8'h00);
        v.push_back(mk(1, 0, 1, 8'h00, ex(3, C0, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h6F, ex(1, C_RD, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h6F, ex(2, C_IR, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h6F, ex(3, C0, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h27, ex(4, C_AE, 4'h6, 0)));
        v.push_back(mk(1, 0, 1, 8'h27, ex(1, C_RD, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h27, ex(2, C_IR, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h27, ex(3, C0, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h00, ex(4, C_AE, 4'h2, 0)));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            got = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("FAIL b2b[%0d] got=%h want=%h", i, got, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        logic [14:0] got, want;
        do_reset();
        prologue(8'h3A);
        v.push_back(mk(1, 0, 0, 8'h3A, ex(3, C0, 0, 0)));
        for (int k = 0; k < 3; k++) v.push_back(mk(1, 0, 0, 8'h3A, ex(5, C_RD, 4'h3, 0)));
        v.push_back(mk(1, 0, 1, 8'h3A, ex(5, C_LDA, 4'h3, 0)));
        v.push_back(mk(1, 0, 0, 8'h3A, ex(1, C_RD, 0, 0)));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            got = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("FAIL load[%0d] got=%h want=%h", i, got, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_skz_jmp();
        logic [14:0] got, want;
        do_reset();
        prologue(8'h70);
        v.push_back(mk(1, 1, 1, 8'h70, ex(3, C0, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h70, ex(4, C_PI, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h70, ex(1, C_RD, 0, 0)));
        v.push_back(mk(1, 1, 1, 8'h70, ex(2, C_IR, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h70, ex(3, C0, 0, 0)));
        v.push_back(mk(1, 1, 1, 8'h85, ex(4, C0, 0, 0)));
        v.push_back(mk(1, 1, 1, 8'h85, ex(1, C_RD, 0, 0)));
        v.push_back(mk(1, 1, 1, 8'h85, ex(2, C_IR, 0, 0)));
        v.push_back(mk(1, 1, 1, 8'h85, ex(3, C0, 0, 0)));
        v.push_back(mk(1, 1, 1, 8'h85, ex(4, C_PL, 0, 0)));
        v.push_back(mk(1, 1, 1, 8'h85, ex(1, C_RD, 0, 0)));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            got = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("FAIL skz_jmp[%0d] got=%h want=%h", i, got, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        logic [14:0] got, want;
        do_reset();
        prologue(8'hF0);
        v.push_back(mk(0, 0, 1, 8'hF0, ex(3, C0, 0, 0)));
        for (int k = 0; k < 5; k++) v.push_back(mk(0, 0, 1, 8'hF0, ex(6, C0, 0, 2'b10)));
        v.push_back(mk(1, 0, 1, 8'hF0, ex(6, C0, 0, 2'b10)));
        v.push_back(mk(1, 0, 1, 8'hF0, ex(1, C_RD, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'hF0, ex(2, C_IR, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'hF0, ex(3, C0, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'hF0, ex(6, C0, 0, 2'b10)));
        v.push_back(mk(1, 0, 1, 8'hF0, ex(1, C_RD, 0, 0)));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            got = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("FAIL halt[%0d] got=%h want=%h", i, got, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        logic [14:0] got, want;
        do_reset();
        v.push_back(mk(1, 0, 0, 8'h15, ex(0, C0, 0, 0)));
        for (int k = 0; k < 15; k++) v.push_back(mk(1, 0, 0, 8'h15, ex(1, C_RD, 0, 0)));
        for (int k = 0; k < 3; k++) v.push_back(mk(1, 0, 1, 8'h15, ex(7, C0, 0, 2'b01)));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            got = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("FAIL timeout[%0d] got=%h want=%h", i, got, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_ready_at_limit_and_illegal();
        logic [14:0] got, want;
        do_reset();
        v.push_back(mk(1, 0, 0, 8'h93, ex(0, C0, 0, 0)));
        for (int k = 0; k < 14; k++) v.push_back(mk(1, 0, 0, 8'h93, ex(1, C_RD, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h93, ex(1, C_RD, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h93, ex(2, C_IR, 0, 0)));
        v.push_back(mk(1, 0, 1, 8'h93, ex(3, C0, 0, 0)));
        for (int k = 0; k < 2; k++) v.push_back(mk(1, 0, 1, 8'h15, ex(7, C0, 0, 2'b01)));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            got = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("FAIL limit_illegal[%0d] got=%h want=%h", i, got, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [14:0] got, want;
        do_reset();
        prologue(8'h4C);
        v.push_back(mk(1, 0, 0, 8'h4C, ex(3, C0, 0, 0)));
        v.push_back(mk(1, 0, 0, 8'h4C, ex(5, C_WR, 0, 0)));
        v.push_back(mk(1, 0, 0, 8'h4C, ex(5, C_WR, 0, 0)));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            got = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin failures++; $display("FAIL store[%0d] got=%h want=%h", i, got, want); end
            if (i < v.size() - 1) @(negedge clk);
        end
        #1;
        reset = 1'b1;
        sb.push_back(ex(0, C0, 0, 0));
        #1;
        got = obs();
        want = sb.pop_front();
        checks++;
        if (got !== want) begin failures++; $display("FAIL reset_mid_store got=%h want=%h", got, want); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_load();
        test_skz_jmp();
        test_halt();
        test_timeout();
        test_ready_at_limit_and_illegal();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle instruction sequencer for the 8-bit accumulator CPU. Generalised successor to the single-cycle controller.
- Walks each instruction through FETCH, DECODE, EXECUTE and MEMORY phases, and handshakes with memory through mem_ready.
- Adds program-counter control, conditional skip, jump, halt/resume and a bus-timeout fault.
- Sits between instruction register, accumulator/ALU, PC and memory.

Parameters:
- INSTR_W, 8: instruction register width; opcode is instruction[INSTR_W-1 -: OPC_W].
- OPC_W, 4: opcode field width (minimum 4).
- WAIT_MAX, 15: maximum cycles to wait for mem_ready before faulting (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  start from IDLE / resume from HALTED (level-sampled).
- instruction  in  INSTR_W  instruction register output.
- acc_zero  in  1  accumulator equals zero.
- mem_ready  in  1  memory completes current read/write this cycle.
- instr_en  out  1  load instruction register.
- pc_inc  out  1  increment PC.
- pc_load  out  1  load PC from operand field.
- acc_en  out  1  load accumulator.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- alu_op  out  4  ALU function select.
- halt  out  1  core halted.
- fault  out  1  illegal opcode or bus timeout; sticky.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset (async): state=IDLE, opcode register=0, wait counter=0. All outputs 0.
- States and encodings: IDLE=0, FETCH=1, LOADIR=2, DECODE=3, EXEC=4, MEMACC=5, HALTED=6, FAULT=7.
- Outputs are decoded from state and the latched opcode. acc_en in MEMACC additionally equals mem_ready. No other input-to-output combinational path.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: mem_rd=1.
  - On mem_ready go to LOADIR.
  - Otherwise increment the wait counter. If the counter reaches WAIT_MAX, go to FAULT.
- LOADIR: instr_en=1 and pc_inc=1 for exactly 1 cycle. Clear the wait counter. Go to DECODE.
- DECODE: latch the opcode from instruction and the acc_zero snapshot. Then branch on opcode:
  - 0000 NOP: go to FETCH.
  - 0001 ADD, 0010 SUB, 0101 AND, 0110 XOR: go to EXEC.
  - 0011 LOAD, 0100 STORE: go to MEMACC.
  - 0111 SKZ: go to EXEC.
  - 1000 JMP: go to EXEC.
  - 1111 HALT: go to HALTED.
  - Any other opcode: go to FAULT.
- EXEC (1 cycle, then FETCH):
  - ALU ops: alu_op equals the opcode, acc_en=1.
  - SKZ: pc_inc=1 only if the latched acc_zero=1.
  - JMP: pc_load=1.
- MEMACC:
  - LOAD: mem_rd=1, alu_op=0011 (pass B).
  - STORE: mem_wr=1.
  - Request is held until mem_ready, then go to FETCH. For LOAD, acc_en=1 in the mem_ready cycle.
  - Timeout rule is the same as FETCH. The counter clears on every state exit.
- HALTED: halt=1.
  - Go to FETCH when run=1 for the first cycle after halt has been high for at least 1 cycle.
  - run held high continuously through entry resumes the cycle after entry.
- FAULT: fault=1, all other outputs 0. Terminal until reset.
- alu_op=0 in every state and opcode not listed above.
- Latency: ALU op is 4 cycles plus fetch wait. LOAD/STORE is 4 cycles plus 2 memory waits.
- Simultaneous events:
  - mem_ready in the same cycle the counter reaches WAIT_MAX: mem_ready wins, no fault.
  - reset mid-state: immediate return to IDLE, outputs 0 asynchronously.
- mem_ready outside FETCH/MEMACC is ignored.
- Wait counter width is clog2(WAIT_MAX+1) and it never wraps.

Test Plan:
- Reset, run=1, mem_ready=1 always, instruction=0x15 (ADD): state sequence 0,1,2,3,4,1. acc_en=1 and alu_op=0001 in EXEC only. pc_inc 1 cycle in LOADIR.
- LOAD 0x3A, mem_ready delayed 3 cycles in MEMACC: mem_rd held 4 cycles. acc_en=1 only in the mem_ready cycle. Next state FETCH.
- SKZ 0x70 with acc_zero=1 then acc_zero=0: pc_inc pulse in EXEC only for the first case. JMP 0x85: pc_load=1 for 1 cycle.
- HALT 0xF0 with run=0, then run=1 after 5 cycles: halt=1 throughout HALTED, then FETCH re-entered.
- mem_ready never asserted in FETCH with WAIT_MAX=15: FAULT after 15 wait cycles, fault=1 sticky. Opcode 0x9x also gives FAULT.
- reset asserted mid-MEMACC STORE: mem_wr drops immediately, state=IDLE, all outputs 0.
